// File: rtl/bus_slave_port.sv
// Slave side of the serial bus. Decodes the LSB-first address frame, acknowledges
// frames whose upper ID bits match SLAVE_ID, strobes writes into the local memory
// and serializes local read data back onto the bus.
//
//   state    | meaning
//   IDLE     | no frame; waits for B_UTIL
//   ADDR     | shifting in address bits 1..ADDR_W-1
//   ACK_A    | two-cycle address acknowledge; read strobe / read data capture
//   WDATA    | shifting in DATA_W write-data bits
//   WSTB     | one-cycle local write strobe
//   ACK_W    | two-cycle write acknowledge
//   RSEND    | driving DATA_W read bits, LSB first
//   WAIT_END | frame done or not ours; waits for B_UTIL low
module bus_slave_port #(
   parameter int               ADDR_W   = 16,
   parameter int               DATA_W   = 8,
   parameter int               ID_W     = 4,
   parameter logic [ID_W-1:0]  SLAVE_ID = 4'h1,
   localparam int              MEM_AW   = ADDR_W - ID_W
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              B_UTIL,
   input  logic              B_RW,
   input  logic              B_BUS,
   output logic              B_BUS_OUT,
   output logic              B_BUS_OE,
   output logic              B_ACK,
   output logic [MEM_AW-1:0] S_ADDR,
   output logic [DATA_W-1:0] S_WDATA,
   output logic              S_WE,
   output logic              S_RE,
   input  logic [DATA_W-1:0] S_RDATA,
   output logic              S_BSY
);

   localparam int MAX_N = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_N);
   localparam logic [CNT_W-1:0] LAST_A = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ACK_A, WDATA, WSTB, ACK_W, RSEND, WAIT_END
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                rw_q;
   logic [ADDR_W-2:0]   addr_q;
   logic [DATA_W-2:0]   wsh_q;
   logic [DATA_W-2:0]   rsh_q;
   logic                ack_q;
   logic                oe_q;
   logic                out_q;
   logic                we_q;
   logic                re_q;
   logic [MEM_AW-1:0]   s_addr_q;
   logic [DATA_W-1:0]   s_wdata_q;

   // Complete words as they stand when their last bit is on the bus.
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wdata_d;

   assign addr_d  = {B_BUS, addr_q};
   assign wdata_d = {B_BUS, wsh_q};

   // Frame sequencer with all bus and local-memory outputs registered.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         wsh_q     <= '0;
         rsh_q     <= '0;
         ack_q     <= 1'b0;
         oe_q      <= 1'b0;
         out_q     <= 1'b0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
      end else begin
         we_q <= 1'b0;
         re_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (B_UTIL) begin
                  rw_q    <= B_RW;
                  addr_q  <= {B_BUS, addr_q[ADDR_W-2:1]};
                  cnt_q   <= CNT_W'(1);
                  state_q <= ADDR;
               end
            end
            ADDR: begin
               if (!B_UTIL) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (cnt_q == LAST_A) begin
                  cnt_q <= '0;
                  if (addr_d[ADDR_W-1 -: ID_W] == SLAVE_ID) begin
                     s_addr_q <= addr_d[MEM_AW-1:0];
                     ack_q    <= 1'b1;
                     re_q     <= ~rw_q;
                     state_q  <= ACK_A;
                  end else begin
                     state_q <= WAIT_END;
                  end
               end else begin
                  addr_q <= {B_BUS, addr_q[ADDR_W-2:1]};
                  cnt_q  <= cnt_q + CNT_W'(1);
               end
            end
            ACK_A: begin
               if (!B_UTIL) begin
                  ack_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (cnt_q == '0) begin
                  cnt_q <= CNT_W'(1);
               end else begin
                  ack_q <= 1'b0;
                  cnt_q <= '0;
                  if (rw_q) begin
                     state_q <= WDATA;
                  end else begin
                     // Memory answers one clock after S_RE, i.e. now.
                     rsh_q   <= S_RDATA[DATA_W-1:1];
                     out_q   <= S_RDATA[0];
                     oe_q    <= 1'b1;
                     state_q <= RSEND;
                  end
               end
            end
            WDATA: begin
               if (!B_UTIL) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (cnt_q == LAST_D) begin
                  s_wdata_q <= wdata_d;
                  we_q      <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= WSTB;
               end else begin
                  wsh_q <= {B_BUS, wsh_q[DATA_W-2:1]};
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WSTB: begin
               // The strobe has already gone out, so an abort here keeps the write.
               ack_q   <= B_UTIL;
               state_q <= B_UTIL ? ACK_W : IDLE;
            end
            ACK_W: begin
               if (!B_UTIL) begin
                  ack_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (cnt_q == '0) begin
                  cnt_q <= CNT_W'(1);
               end else begin
                  ack_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= WAIT_END;
               end
            end
            RSEND: begin
               if (!B_UTIL || cnt_q == LAST_D) begin
                  oe_q    <= 1'b0;
                  out_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= B_UTIL ? WAIT_END : IDLE;
               end else begin
                  out_q <= rsh_q[0];
                  rsh_q <= {1'b0, rsh_q[DATA_W-2:1]};
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WAIT_END: begin
               if (!B_UTIL) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign B_ACK     = ack_q;
   assign B_BUS_OE  = oe_q;
   assign B_BUS_OUT = out_q;
   assign S_WE      = we_q;
   assign S_RE      = re_q;
   assign S_ADDR    = s_addr_q;
   assign S_WDATA   = s_wdata_q;
   assign S_BSY     = (state_q != IDLE);

endmodule
